// File: rtl/latch_ex_mem_if.sv
// EX->MEM pipeline register bus: EX-side results and controller decisions in,
// registered MEM-side results and multiply-accumulate feedback out.
interface latch_ex_mem_if;
    logic        flush;
    logic        stall_ex;
    logic        stall_mem;

    logic        ex_register_write_enable;
    logic [4:0]  ex_register_write_address;
    logic [31:0] ex_register_write_data;
    logic        ex_register_hi_write_enable;
    logic [31:0] ex_register_hi_write_data;
    logic        ex_register_lo_write_enable;
    logic [31:0] ex_register_lo_write_data;
    logic [7:0]  ex_memory_operator;
    logic [31:0] ex_memory_address;
    logic [31:0] ex_memory_store_data;
    logic [63:0] ex_accumulate_data;
    logic [1:0]  ex_accumulate_count;

    logic        mem_register_write_enable;
    logic [4:0]  mem_register_write_address;
    logic [31:0] mem_register_write_data;
    logic        mem_register_hi_write_enable;
    logic [31:0] mem_register_hi_write_data;
    logic        mem_register_lo_write_enable;
    logic [31:0] mem_register_lo_write_data;
    logic [7:0]  mem_memory_operator;
    logic [31:0] mem_memory_address;
    logic [31:0] mem_memory_store_data;
    logic [63:0] accumulate_data;
    logic [1:0]  accumulate_count;

    modport master (
        output flush, stall_ex, stall_mem,
        output ex_register_write_enable, ex_register_write_address, ex_register_write_data,
        output ex_register_hi_write_enable, ex_register_hi_write_data,
        output ex_register_lo_write_enable, ex_register_lo_write_data,
        output ex_memory_operator, ex_memory_address, ex_memory_store_data,
        output ex_accumulate_data, ex_accumulate_count,
        input  mem_register_write_enable, mem_register_write_address, mem_register_write_data,
        input  mem_register_hi_write_enable, mem_register_hi_write_data,
        input  mem_register_lo_write_enable, mem_register_lo_write_data,
        input  mem_memory_operator, mem_memory_address, mem_memory_store_data,
        input  accumulate_data, accumulate_count
    );

    modport slave (
        input  flush, stall_ex, stall_mem,
        input  ex_register_write_enable, ex_register_write_address, ex_register_write_data,
        input  ex_register_hi_write_enable, ex_register_hi_write_data,
        input  ex_register_lo_write_enable, ex_register_lo_write_data,
        input  ex_memory_operator, ex_memory_address, ex_memory_store_data,
        input  ex_accumulate_data, ex_accumulate_count,
        output mem_register_write_enable, mem_register_write_address, mem_register_write_data,
        output mem_register_hi_write_enable, mem_register_hi_write_data,
        output mem_register_lo_write_enable, mem_register_lo_write_data,
        output mem_memory_operator, mem_memory_address, mem_memory_store_data,
        output accumulate_data, accumulate_count
    );
endinterface

// File: rtl/latch_ex_mem.sv
// EX->MEM pipeline register with stall/flush handling and the two-step
// multiply-accumulate carry (partial product + step count) fed back to EX.
module latch_ex_mem (
    input  logic           clock,
    input  logic           reset,
    latch_ex_mem_if.slave  bus
);
    typedef struct packed {
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [31:0] reg_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic [7:0]  mem_op;
        logic [31:0] mem_addr;
        logic [31:0] mem_sdata;
    } pipe_t;

    pipe_t       pipe_q;
    pipe_t       pipe_d;
    logic [63:0] acc_data_q;
    logic [1:0]  acc_count_q;

    assign pipe_d = '{
        reg_we:    bus.ex_register_write_enable,
        reg_waddr: bus.ex_register_write_address,
        reg_wdata: bus.ex_register_write_data,
        hi_we:     bus.ex_register_hi_write_enable,
        hi_wdata:  bus.ex_register_hi_write_data,
        lo_we:     bus.ex_register_lo_write_enable,
        lo_wdata:  bus.ex_register_lo_write_data,
        mem_op:    bus.ex_memory_operator,
        mem_addr:  bus.ex_memory_address,
        mem_sdata: bus.ex_memory_store_data
    };

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            pipe_q      <= '0;
            acc_data_q  <= '0;
            acc_count_q <= '0;
        end else if (bus.stall_ex && !bus.stall_mem) begin
            // Bubble into MEM while EX keeps working on its multi-cycle op.
            pipe_q      <= '0;
            acc_data_q  <= bus.ex_accumulate_data;
            acc_count_q <= bus.ex_accumulate_count;
        end else if (!bus.stall_mem) begin
            pipe_q      <= pipe_d;
            acc_data_q  <= '0;
            acc_count_q <= '0;
        end
        // stall_mem=1 (with or without stall_ex) holds both groups.
    end

    assign bus.mem_register_write_enable    = pipe_q.reg_we;
    assign bus.mem_register_write_address   = pipe_q.reg_waddr;
    assign bus.mem_register_write_data      = pipe_q.reg_wdata;
    assign bus.mem_register_hi_write_enable = pipe_q.hi_we;
    assign bus.mem_register_hi_write_data   = pipe_q.hi_wdata;
    assign bus.mem_register_lo_write_enable = pipe_q.lo_we;
    assign bus.mem_register_lo_write_data   = pipe_q.lo_wdata;
    assign bus.mem_memory_operator          = pipe_q.mem_op;
    assign bus.mem_memory_address           = pipe_q.mem_addr;
    assign bus.mem_memory_store_data        = pipe_q.mem_sdata;
    assign bus.accumulate_data              = acc_data_q;
    assign bus.accumulate_count             = acc_count_q;
endmodule

// File: doc/latch_ex_mem.md
# latch_ex_mem

Pipeline register between the execute stage and the memory stage. Captures EX results (GPR write-back, HI/LO write-back, memory access request) on each clock and presents them to MEM and to the EX forwarding paths. Applies the pipeline controller's stall/flush decisions. Also holds the partial 64-bit product and step counter that two-cycle multiply-accumulate operations (MADD/MSUB family) carry across the stall they raise in EX.

## Interface
- No parameters; all widths are fixed by the ISA.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `flush` in 1: discard the in-flight EX instruction (exception/eret); priority below `reset`, above stalls.
- `stall_ex` in 1: EX stage stalled this cycle.
- `stall_mem` in 1: MEM stage stalled this cycle.
- `ex_register_write_enable` in 1 / `ex_register_write_address` in 5 / `ex_register_write_data` in 32: GPR write-back from EX.
- `ex_register_hi_write_enable` in 1 / `ex_register_hi_write_data` in 32: HI write-back from EX.
- `ex_register_lo_write_enable` in 1 / `ex_register_lo_write_data` in 32: LO write-back from EX.
- `ex_memory_operator` in 8: load/store operator code; 0 = no access.
- `ex_memory_address` in 32 / `ex_memory_store_data` in 32: effective address and store data.
- `ex_accumulate_data` in 64 / `ex_accumulate_count` in 2: partial product and step counter produced by EX.
- `mem_register_write_enable` out 1 / `mem_register_write_address` out 5 / `mem_register_write_data` out 32: registered GPR write-back.
- `mem_register_hi_write_enable` out 1 / `mem_register_hi_write_data` out 32.
- `mem_register_lo_write_enable` out 1 / `mem_register_lo_write_data` out 32.
- `mem_memory_operator` out 8 / `mem_memory_address` out 32 / `mem_memory_store_data` out 32.
- `accumulate_data` out 64 / `accumulate_count` out 2: registered feedback to EX.

## Operation
- Two register groups. Pipeline group: all `mem_*` outputs. Accumulate group: `accumulate_data`, `accumulate_count`.
- Per-edge action, first matching rule wins:
  - `reset`=1: both groups cleared. All data outputs 0, all write enables disabled, operator 0.
  - `flush`=1: both groups cleared, same as reset.
  - `stall_ex`=1, `stall_mem`=0 (bubble): pipeline group cleared (enables disabled, data 0, operator 0). Accumulate group loads `ex_accumulate_data`/`ex_accumulate_count`.
  - `stall_ex`=1, `stall_mem`=1 (hold): both groups keep their values.
  - `stall_ex`=0, `stall_mem`=1: illegal from the controller. The block treats it as hold; the bench flags it with an assertion.
  - `stall_ex`=0, `stall_mem`=0 (advance): pipeline group loads all `ex_*` values unchanged. Accumulate group clears to 0.
- EX uses the accumulate group as follows:
  - Step 0 (count 0): EX stalls itself and presents the product with count 1.
  - Step 1 (count 1, fed back here): EX completes and presents count 2 with `stall_ex`=0, which clears the group.
- Count value 3 is never produced. If loaded, it is stored verbatim; the block does not interpret it.
- No arithmetic is done here. Values pass bit-exact, with no width change or sign extension.

## Timing
- Latency: one cycle. EX values present before edge N appear on `mem_*` after edge N.
- All outputs are registered. There is no combinational path from any input to any output.
- A bubble occupies exactly one MEM cycle for each cycle that `stall_ex`=1 and `stall_mem`=0.
- Accumulate feedback is available to EX in the cycle after the bubble edge. Two-cycle MADD therefore costs exactly one bubble.
- `flush` asserted together with any stall combination still clears both groups at that edge.
- `reset` deasserted at edge N: the first capture happens at edge N+1.
- Reset mid-multiply-accumulate: the count returns to 0. The aborted op leaves no HI/LO write pending.

## Test plan
- Reset: hold `reset`=1 for 2 edges with all `ex_*` at all-ones. Then every output is 0 and every enable is disabled; on release, the first advance captures the inputs.
- Advance: drive GPR en=1, addr=5'd9, data=32'hDEADBEEF, memory_operator=8'h23, address=32'h0000_0100. One edge later the `mem_*` outputs equal these values exactly.
- Bubble, then hold: load a valid instruction, then `stall_ex`=1/`stall_mem`=0 for 1 edge. `mem_register_write_enable`=0 and data=0. Then 1/1 for 3 edges: the outputs and the accumulate group are unchanged.
- MADD sequence:
  - Edge 1: `stall_ex`=1/`stall_mem`=0, `ex_accumulate_data`=64'h0000_0001_0000_0002, count=1 → accumulate outputs show that value and count 1.
  - Edge 2: `stall_ex`=0, HI/LO enables=1 → accumulate cleared to 0; HI/LO values appear on `mem_*`.
- Flush priority: assert `flush`=1 with `stall_ex`=1/`stall_mem`=1 while the accumulate count is 1 → all outputs 0 and count 0 after the edge.
- Illegal stall: drive `stall_ex`=0/`stall_mem`=1 → state held; the assertion fires once per occurrence.
